ins_fetch: RTL and testbench

Instruction fetch unit: the initiator side of the 256-word × 16-bit instruction memory. It owns the program counter, drives the memory's 8-bit word address, and captures the returned 16-bit instruction. It presents the instruction, with its PC, to the decode stage through a valid/ready handshake. Sits between the instruction memory and decode; accepts branch/jump redirects from execute.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ins_pc.sv | 30 +++
 rtl/ins_fetch.sv | 101 ++++++++++
 tb/tb_ins_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: instruction/address widths, the halt
// opcode, and the fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int INS_W  = 16;

  localparam logic [15:0] HALT_INS = 16'o177777;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/ins_pc.sv
// Program counter register: synchronous reset, redirect load, mod-2^ADDR_W
// increment.
module ins_pc #(
  parameter int                  ADDR_W   = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  // Load wins over inc; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load) begin
      r_pc <= load_addr;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory and hands the
// instruction to decode over valid/ready. Optional halt support: INS_FETCH_HALT_EN.
module ins_fetch #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INS_W    = cpu_pkg::INS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_ins,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ir_valid,
  output logic [INS_W-1:0]  ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  output logic [15:0]       fetch_cnt
);

  import cpu_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_ir_valid;
  logic [INS_W-1:0]  r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic [15:0]       r_fetch_cnt;
  logic [ADDR_W-1:0] w_pc;
  logic              w_load;
  logic              w_is_halt;
  logic              w_pc_inc;

  ins_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .inc       (w_pc_inc),
    .load      (redirect_valid),
    .load_addr (redirect_addr),
    .pc        (w_pc)
  );

  assign w_load = (r_state == RUN) && !redirect_valid && (!r_ir_valid || ir_ready);

`ifdef INS_FETCH_HALT_EN
  assign w_is_halt = (imem_ins == INS_W'(HALT_INS));
`else
  assign w_is_halt = 1'b0;
`endif

  // A captured halt parks the PC on the halt address instead of advancing.
  assign w_pc_inc = w_load && !w_is_halt;

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = RUN;
    end else if (w_load && w_is_halt) begin
      w_state_nxt = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect discards a held instruction even when decode is ready this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_valid  <= 1'b0;
      r_ir        <= '0;
      r_ir_pc     <= '0;
      r_fetch_cnt <= '0;
    end else if (redirect_valid) begin
      r_ir_valid <= 1'b0;
    end else if (w_load) begin
      r_ir       <= imem_ins;
      r_ir_pc    <= w_pc;
      r_ir_valid <= 1'b1;
      if (r_fetch_cnt != '1) begin
        r_fetch_cnt <= r_fetch_cnt + 1'b1;
      end
    end else if (ir_ready) begin
      r_ir_valid <= 1'b0;
    end
  end

  assign imem_addr = w_pc;
  assign ir_valid  = r_ir_valid;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed scenarios plus randomized traffic, checked by a
// delivered-stream scoreboard and a cycle-level reference model.
module tb_ins_fetch;

  localparam int AW = 8;
  localparam int IW = 16;
`ifdef INS_FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_ins;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          ir_valid;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_ready = 1'b0;
  logic [15:0]   fetch_cnt;

  logic [IW-1:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  ins_fetch #(.ADDR_W(AW), .INS_W(IW), .RESET_PC(8'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_ins       (imem_ins),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .ir_valid       (ir_valid),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready),
    .fetch_cnt      (fetch_cnt)
  );

  assign imem_ins = mem[imem_addr];

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the stream decode should accept after a (re)start at address A
  // is simply mem[A], mem[A+1], ... (ending at a halt word when halting is built in).
  typedef struct packed {
    logic [IW-1:0] ins;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t          sb_q[$];
  logic [AW-1:0] sb_pc;
  bit            sb_done;

  function automatic void sb_fill();
    while (sb_q.size() < 8 && !sb_done) begin
      sb_q.push_back(exp_t'{ins: mem[sb_pc], pc: sb_pc});
      if (HALT_EN && mem[sb_pc] == 16'o177777) sb_done = 1'b1;
      else sb_pc = sb_pc + 8'd1;
    end
  endfunction

  function automatic void sb_restart(input logic [AW-1:0] a);
    sb_q.delete();
    sb_pc   = a;
    sb_done = 1'b0;
    sb_fill();
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ir_valid === 1'b1 && ir_ready && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: accepted ir_pc=%0d ir=%o, none expected at %0t", ir_pc, ir, $time);
      end else begin
        e = sb_q.pop_front();
        check("sb_ins", 32'(ir), 32'(e.ins));
        check("sb_pc", 32'(ir_pc), 32'(e.pc));
        sb_fill();
      end
    end
  end

  // Cycle-level reference: pc, whether ir holds something, and the load count.
  bit            m_known = 1'b0;
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_irpc;
  logic [15:0]   m_cnt;
  bit            m_halt;

  always @(negedge clk) begin
    if (m_known) begin
      check("m_valid", 32'(ir_valid), 32'(m_valid));
      check("m_addr", 32'(imem_addr), 32'(m_pc));
      check("m_cnt", 32'(fetch_cnt), 32'(m_cnt));
      if (m_valid) begin
        check("m_ir_pc", 32'(ir_pc), 32'(m_irpc));
        check("m_ir", 32'(ir), 32'(mem[m_irpc]));
      end
    end
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_pc    = 8'd0;
      m_irpc  = 8'd0;
      m_cnt   = 16'd0;
      m_halt  = 1'b0;
    end else if (m_known) begin
      if (redirect_valid) begin
        m_pc    = redirect_addr;
        m_valid = 1'b0;
        m_halt  = 1'b0;
      end else if (!m_halt && (!m_valid || ir_ready)) begin
        m_irpc  = m_pc;
        m_valid = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (HALT_EN && mem[m_pc] == 16'o177777) m_halt = 1'b1;
        else m_pc = m_pc + 8'd1;
      end else if (ir_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    ir_ready       = 1'b0;
    tick();
    rst = 1'b0;
    sb_restart(8'd0);
  endtask

  task automatic redirect_to(input logic [AW-1:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    sb_restart(a);
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom());
      if (mem[i] == 16'hFFFF) mem[i] = 16'h0000;
    end
    mem[0]   = 16'o001200;
    mem[1]   = 16'o011001;
    mem[2]   = 16'o021002;
    mem[4]   = 16'o177777;
    mem[9]   = 16'o030777;
    mem[255] = 16'o000100;

    // Streaming from reset
    do_reset();
    ir_ready = 1'b1;
    check("c0_valid", 32'(ir_valid), 32'd0);
    check("c0_addr", 32'(imem_addr), 32'd0);
    check("c0_cnt", 32'(fetch_cnt), 32'd0);
    check("c0_ir", 32'(ir), 32'd0);
    check("c0_ir_pc", 32'(ir_pc), 32'd0);
    tick();
    check("c1_ir", 32'(ir), 32'(16'o001200));
    check("c1_ir_pc", 32'(ir_pc), 32'd0);
    tick();
    check("c2_ir", 32'(ir), 32'(16'o011001));
    check("c2_ir_pc", 32'(ir_pc), 32'd1);
    tick();
    check("c3_ir", 32'(ir), 32'(16'o021002));
    check("c3_ir_pc", 32'(ir_pc), 32'd2);
    check("c3_cnt", 32'(fetch_cnt), 32'd3);

    // Backpressure in cycles 2..5
    do_reset();
    ir_ready = 1'b1;
    tick();
    tick();
    for (int c = 2; c <= 5; c++) begin
      ir_ready = 1'b0;
      check("bp_ir", 32'(ir), 32'(16'o011001));
      check("bp_ir_pc", 32'(ir_pc), 32'd1);
      check("bp_valid", 32'(ir_valid), 32'd1);
      check("bp_addr", 32'(imem_addr), 32'd2);
      tick();
    end
    ir_ready = 1'b1;
    check("bp_rel_ir", 32'(ir), 32'(16'o011001));
    tick();
    check("bp_next_ir", 32'(ir), 32'(16'o021002));
    check("bp_next_pc", 32'(ir_pc), 32'd2);

    // Redirect to 9 while held, then wrap through 255
    do_reset();
    ir_ready = 1'b1;
    tick();
    tick();
    tick();
    ir_ready = 1'b0;
    redirect_to(8'd9);
    check("rd_bubble", 32'(ir_valid), 32'd0);
    check("rd_addr", 32'(imem_addr), 32'd9);
    check("rd_cnt", 32'(fetch_cnt), 32'd3);
    ir_ready = 1'b1;
    tick();
    check("rd_ir", 32'(ir), 32'(16'o030777));
    check("rd_ir_pc", 32'(ir_pc), 32'd9);
    check("rd_cnt2", 32'(fetch_cnt), 32'd4);
    redirect_to(8'd255);
    check("wr_bubble", 32'(ir_valid), 32'd0);
    check("wr_addr", 32'(imem_addr), 32'd255);
    tick();
    check("wr_ir255", 32'(ir), 32'(16'o000100));
    check("wr_pc255", 32'(ir_pc), 32'd255);
    tick();
    check("wr_ir0", 32'(ir), 32'(16'o001200));
    check("wr_pc0", 32'(ir_pc), 32'd0);

    // Halt word at address 4
    do_reset();
    ir_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("h_ir_pc", 32'(ir_pc), 32'd4);
    check("h_ir", 32'(ir), 32'(16'o177777));
    tick();
`ifdef INS_FETCH_HALT_EN
    for (int c = 0; c < 4; c++) begin
      check("h_idle_valid", 32'(ir_valid), 32'd0);
      check("h_idle_cnt", 32'(fetch_cnt), 32'd5);
      check("h_idle_addr", 32'(imem_addr), 32'd4);
      tick();
    end
    redirect_to(8'd0);
    tick();
    check("h_resume_ir", 32'(ir), 32'(16'o001200));
    check("h_resume_pc", 32'(ir_pc), 32'd0);
`else
    check("h_next_valid", 32'(ir_valid), 32'd1);
    check("h_next_pc", 32'(ir_pc), 32'd5);
    check("h_next_cnt", 32'(fetch_cnt), 32'd6);
`endif

    // Reset in cycle 6 of streaming
    do_reset();
    ir_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_restart(8'd0);
    check("rs_valid", 32'(ir_valid), 32'd0);
    check("rs_addr", 32'(imem_addr), 32'd0);
    check("rs_cnt", 32'(fetch_cnt), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      ir_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_restart(8'd0);
      end else if (r < 14) begin
        redirect_to(8'($urandom_range(0, 255)));
      end else begin
        tick();
      end
    end
    ir_ready = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
